// File: rtl/wave_pkg.sv
// -----------------------------------------------------------------------------
// wave_pkg
//   Types and defaults used by the waveform capture buffer. It holds the
//   capture FSM state type and the default sample width and geometry.
//   There are no ports. Import it with: import wave_pkg::*;
// -----------------------------------------------------------------------------
package wave_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int DEPTH_DEF    = 512;
    localparam int PRE_TRIG_DEF = 64;

    // Capture sequence:
    // IDLE -> PRETRIG (fill the pre-trigger history) -> ARMED (wait for the
    // rising crossing) -> POST (finish the record) -> READ (stream it out).
    typedef enum logic [2:0] {
        IDLE,
        PRETRIG,
        ARMED,
        POST,
        READ
    } cap_state_e;

endpackage : wave_pkg

// File: rtl/wave_sdp_ram.sv
// -----------------------------------------------------------------------------
// wave_sdp_ram
//   Simple dual-port sample RAM. It has one write port and one read port.
//   A read returns its data one clock after rd_en is asserted.
//   The RAM has no reset, so the whole array can map onto a block RAM.
// Ports
//   clk      in   1       clock
//   wr_en    in   1       write strobe
//   wr_addr  in   ADDR_W  write address
//   wr_data  in   DATA_W  write data
//   rd_en    in   1       read strobe; rd_data updates on the next edge
//   rd_addr  in   ADDR_W  read address
//   rd_data  out  DATA_W  registered read data
// -----------------------------------------------------------------------------
module wave_sdp_ram #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 512,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the storage array is deliberately left without a reset. Resetting
    // it would block block-RAM inference. No reader ever depends on its
    // initial contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule : wave_sdp_ram

// File: rtl/wave_capture_ram.sv
// -----------------------------------------------------------------------------
// wave_capture_ram
//   Triggered capture buffer for an 8-bit sample stream.
//   - After i_arm, it records PRE_TRIG samples of history.
//   - It then writes circularly until a rising crossing of i_trig_level.
//   - It completes a DEPTH-sample record around the trigger.
//   - It streams the record out oldest-first on a valid/ready port.
// Ports
//   clk, rst_n      clock; asynchronous active-low reset
//   i_arm           start a capture (IDLE only)
//   i_abort         return to IDLE from any state; wins over i_arm
//   i_sample_vld    i_sample carries a sample this cycle
//   i_sample        input sample, unsigned
//   i_trig_level    trigger threshold, unsigned
//   o_busy          high outside IDLE
//   o_trig_addr     RAM address of the trigger sample
//   o_rd_data       readout word
//   o_rd_valid      readout word valid
//   i_rd_ready      readout consumer ready
//   o_rd_last       marks the final (DEPTH-th) readout word
//   o_done          one-cycle pulse after the final readout handshake
// -----------------------------------------------------------------------------
module wave_capture_ram
    import wave_pkg::*;
#(
    parameter  int DATA_W   = DATA_W_DEF,
    parameter  int DEPTH    = DEPTH_DEF,
    parameter  int PRE_TRIG = PRE_TRIG_DEF,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_arm,
    input  logic              i_abort,
    input  logic              i_sample_vld,
    input  logic [DATA_W-1:0] i_sample,
    input  logic [DATA_W-1:0] i_trig_level,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_trig_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    input  logic              i_rd_ready,
    output logic              o_rd_last,
    output logic              o_done
);

    localparam int POST_LEN = DEPTH - PRE_TRIG;  // includes the trigger sample
    localparam int CNT_W    = ADDR_W + 1;

    localparam logic [CNT_W-1:0]  PRE_LAST  = CNT_W'(PRE_TRIG > 0 ? PRE_TRIG - 1 : 0);
    localparam logic [CNT_W-1:0]  POST_LAST = CNT_W'(POST_LEN - 1);
    localparam logic [CNT_W-1:0]  RD_LAST   = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  RD_TOTAL  = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_TRIG);

    cap_state_e        state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [CNT_W-1:0]  fill_cnt;      // samples written in PRETRIG / POST
    logic [DATA_W-1:0] prev_sample;
    logic              prev_vld;      // prev_sample holds a sample from this capture

    // Readout: RAM read in flight -> skid register -> output register.
    logic [ADDR_W-1:0] rd_base;       // oldest sample of the record
    logic [CNT_W-1:0]  rd_cnt;        // RAM reads issued so far
    logic              rd_pend;       // ram_q carries a fresh word this cycle
    logic              rd_pend_last;
    logic              skid_vld;
    logic              skid_last;
    logic [DATA_W-1:0] skid_data;
    logic [DATA_W-1:0] ram_q;

    logic              capturing;
    logic              wr_en;
    logic              trig_hit;
    logic              pop;
    logic              rd_issue;
    logic [ADDR_W-1:0] rd_addr;
    logic [1:0]        occ_next;

    assign o_busy    = (state != IDLE);
    assign capturing = (state == PRETRIG) || (state == ARMED) || (state == POST);
    assign wr_en     = capturing && i_sample_vld && !i_abort;
    assign trig_hit  = (state == ARMED) && i_sample_vld && prev_vld &&
                       (prev_sample < i_trig_level) && (i_sample >= i_trig_level);
    assign pop       = o_rd_valid && i_rd_ready;
    assign rd_addr   = rd_base + rd_cnt[ADDR_W-1:0];

    // A read is issued only when its word will find a free slot on arrival.
    // The slots are the output register and the skid register, after this
    // cycle's pop is accounted for.
    // NOTE: every signal driven from always_comb gets a default value first.
    // Otherwise an incomplete path would infer a latch.
    always_comb begin
        occ_next = 2'(o_rd_valid) + 2'(skid_vld) + 2'(rd_pend) - 2'(pop);
        rd_issue = 1'b0;
        if ((state == READ) && !i_abort && (rd_cnt != RD_TOTAL) && (occ_next < 2'd2)) begin
            rd_issue = 1'b1;
        end
    end

    wave_sdp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (i_sample),
        .rd_en   (rd_issue),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    // NOTE: all state below uses non-blocking assignments. Every register
    // then samples the pre-edge values, whatever the statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            fill_cnt     <= '0;
            prev_sample  <= '0;
            prev_vld     <= 1'b0;
            rd_base      <= '0;
            rd_cnt       <= '0;
            rd_pend      <= 1'b0;
            rd_pend_last <= 1'b0;
            skid_vld     <= 1'b0;
            skid_last    <= 1'b0;
            skid_data    <= '0;
            o_trig_addr  <= '0;
            o_rd_data    <= '0;
            o_rd_valid   <= 1'b0;
            o_rd_last    <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (i_abort) begin
                state      <= IDLE;
                rd_pend    <= 1'b0;
                skid_vld   <= 1'b0;
                o_rd_valid <= 1'b0;
                o_rd_last  <= 1'b0;
            end else begin
                rd_pend      <= rd_issue;
                rd_pend_last <= (rd_cnt == RD_LAST);
                if (rd_issue) begin
                    rd_cnt <= rd_cnt + 1'b1;
                end

                // prev follows every valid sample since arm, in all capture states.
                if (capturing && i_sample_vld) begin
                    prev_sample <= i_sample;
                    prev_vld    <= 1'b1;
                end

                case (state)
                    IDLE: begin
                        if (i_arm) begin
                            wr_ptr   <= '0;
                            fill_cnt <= '0;
                            rd_cnt   <= '0;
                            prev_vld <= 1'b0;
                            state    <= (PRE_TRIG == 0) ? ARMED : PRETRIG;
                        end
                    end

                    PRETRIG: begin
                        if (i_sample_vld) begin
                            wr_ptr   <= wr_ptr + 1'b1;
                            fill_cnt <= fill_cnt + 1'b1;
                            if (fill_cnt == PRE_LAST) begin
                                state <= ARMED;
                            end
                        end
                    end

                    ARMED: begin
                        if (i_sample_vld) begin
                            wr_ptr <= wr_ptr + 1'b1;
                            if (trig_hit) begin
                                o_trig_addr <= wr_ptr;
                                rd_base     <= wr_ptr - PRE_OFS;
                                fill_cnt    <= CNT_W'(1);
                                state       <= (POST_LEN == 1) ? READ : POST;
                            end
                        end
                    end

                    POST: begin
                        if (i_sample_vld) begin
                            wr_ptr   <= wr_ptr + 1'b1;
                            fill_cnt <= fill_cnt + 1'b1;
                            if (fill_cnt == POST_LAST) begin
                                state <= READ;
                            end
                        end
                    end

                    READ: begin
                        if (!o_rd_valid || i_rd_ready) begin
                            // The output register is free: the skid word is
                            // older than anything arriving from the RAM.
                            if (skid_vld) begin
                                o_rd_data  <= skid_data;
                                o_rd_last  <= skid_last;
                                o_rd_valid <= 1'b1;
                                if (rd_pend) begin
                                    skid_data <= ram_q;
                                    skid_last <= rd_pend_last;
                                end else begin
                                    skid_vld <= 1'b0;
                                end
                            end else if (rd_pend) begin
                                o_rd_data  <= ram_q;
                                o_rd_last  <= rd_pend_last;
                                o_rd_valid <= 1'b1;
                            end else begin
                                o_rd_valid <= 1'b0;
                                o_rd_last  <= 1'b0;
                            end
                        end else if (rd_pend) begin
                            // Output is stalled: park the arriving word.
                            skid_data <= ram_q;
                            skid_last <= rd_pend_last;
                            skid_vld  <= 1'b1;
                        end

                        if (pop && o_rd_last) begin
                            o_rd_valid <= 1'b0;
                            o_rd_last  <= 1'b0;
                            o_done     <= 1'b1;
                            state      <= IDLE;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule : wave_capture_ram

// File: tb/tb_wave_capture_ram.sv
// -----------------------------------------------------------------------------
// tb_wave_capture_ram
//   Self-checking bench for wave_capture_ram with its default parameters.
//   Stimulus is generated into a sample list. The reference model finds the
//   trigger index in that list. The expected record is the list slice from
//   trigger-PRE_TRIG to trigger+POST_LEN-1.
// -----------------------------------------------------------------------------
module tb_wave_capture_ram;

    localparam int DATA_W     = 8;
    localparam int DEPTH      = 512;
    localparam int PRE_TRIG   = 64;
    localparam int ADDR_W     = 9;
    localparam int POST_LEN   = DEPTH - PRE_TRIG;
    localparam int CAP_BUDGET = 20000;
    localparam int STIM_LEN   = 1500;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_arm;
    logic              i_abort;
    logic              i_sample_vld;
    logic [DATA_W-1:0] i_sample;
    logic [DATA_W-1:0] i_trig_level;
    logic              o_busy;
    logic [ADDR_W-1:0] o_trig_addr;
    logic [DATA_W-1:0] o_rd_data;
    logic              o_rd_valid;
    logic              i_rd_ready;
    logic              o_rd_last;
    logic              o_done;

    int errors = 0;
    int checks = 0;

    logic [7:0] stim [$];

    always #5 clk = ~clk;

    wave_capture_ram dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_arm        (i_arm),
        .i_abort      (i_abort),
        .i_sample_vld (i_sample_vld),
        .i_sample     (i_sample),
        .i_trig_level (i_trig_level),
        .o_busy       (o_busy),
        .o_trig_addr  (o_trig_addr),
        .o_rd_data    (o_rd_data),
        .o_rd_valid   (o_rd_valid),
        .i_rd_ready   (i_rd_ready),
        .o_rd_last    (o_rd_last),
        .o_done       (o_done)
    );

    // ---------------- reference model ----------------
    // First valid-sample index at or after PRE_TRIG where the stream rises
    // through the level. Index 0 has no predecessor and never triggers.
    function automatic int find_trigger(input logic [7:0] level);
        for (int i = (PRE_TRIG > 0 ? PRE_TRIG : 1); i < stim.size(); i++) begin
            if (stim[i-1] < level && stim[i] >= level) return i;
        end
        return -1;
    endfunction

    task automatic gen_ramp();
        stim.delete();
        for (int i = 0; i < STIM_LEN; i++) stim.push_back(8'(i));
    endtask

    task automatic gen_const(input logic [7:0] v);
        stim.delete();
        for (int i = 0; i < STIM_LEN; i++) stim.push_back(v);
    endtask

    // Crosses 0x80 at sample 10 (during pre-trigger fill), falls back at 20,
    // and crosses again for good at sample 200.
    task automatic gen_double_cross();
        stim.delete();
        for (int i = 0; i < STIM_LEN; i++) begin
            if ((i >= 10 && i < 20) || i >= 200) stim.push_back(8'(8'h80 + $urandom_range(0, 8'h7F)));
            else                                stim.push_back(8'($urandom_range(0, 8'h7F)));
        end
    endtask

    task automatic gen_random();
        stim.delete();
        for (int i = 0; i < STIM_LEN; i++) stim.push_back(8'($urandom));
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic arm(input logic [7:0] level);
        i_trig_level = level;
        i_arm        = 1'b1;
        @(negedge clk);
        i_arm        = 1'b0;
    endtask

    // Stream stim[] one sample per cycle with the readout stalled.
    task automatic stream(input int n, input bit stop_on_valid, output bit saw_valid);
        saw_valid  = 1'b0;
        i_rd_ready = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (o_rd_valid === 1'b1) begin
                saw_valid = 1'b1;
                if (stop_on_valid) break;
            end
            i_sample_vld = (k < stim.size());
            i_sample     = (k < stim.size()) ? stim[k] : 8'h00;
            @(negedge clk);
        end
        i_sample_vld = 1'b0;
    endtask

    // Full capture plus readout, checked word by word against the model.
    task automatic run_capture(input string name, input int vld_every, input int ready_pct,
                               input logic [7:0] level);
        int         t, k, cyc, got, done_cnt, tail;
        logic       stalled;
        logic [7:0] held_data, exp_data;
        logic       held_last, exp_last;
        logic [ADDR_W-1:0] exp_ta;

        t = find_trigger(level);
        if (t < 0 || t + POST_LEN > stim.size()) begin
            errors++;
            $display("FAIL %s stimulus: no usable trigger in model (index %0d)", name, t);
            return;
        end
        exp_ta = ADDR_W'(t % DEPTH);

        arm(level);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_arm: got %b want 1", name, o_busy);
        end

        k = 0; got = 0; done_cnt = 0; cyc = 0; tail = 0;
        stalled = 1'b0; held_data = '0; held_last = 1'b0;
        while (cyc < CAP_BUDGET && tail < 4) begin
            if (o_done === 1'b1) done_cnt++;
            if (got == DEPTH) begin
                if (tail == 0) begin
                    checks++;
                    if (o_done !== 1'b1) begin
                        errors++;
                        $display("FAIL %s done_timing: got %b want 1 right after last handshake", name, o_done);
                    end
                end else if (tail == 1) begin
                    checks++;
                    if (o_done !== 1'b0 || o_rd_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL %s after_done: got done=%b valid=%b want 0/0", name, o_done, o_rd_valid);
                    end
                end
                tail++;
            end
            if (stalled) begin
                checks++;
                if (o_rd_valid !== 1'b1 || o_rd_data !== held_data || o_rd_last !== held_last) begin
                    errors++;
                    $display("FAIL %s stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             name, o_rd_valid, o_rd_data, o_rd_last, held_data, held_last);
                end
            end

            if (k < stim.size() && (cyc % vld_every == 0)) begin
                i_sample_vld = 1'b1;
                i_sample     = stim[k];
                k++;
            end else begin
                i_sample_vld = 1'b0;
                i_sample     = 8'($urandom);
            end
            i_rd_ready = (got < DEPTH) && ($urandom_range(0, 99) < ready_pct);

            if (o_rd_valid === 1'b1 && i_rd_ready) begin
                exp_data = stim[t - PRE_TRIG + got];
                exp_last = (got == DEPTH - 1);
                checks++;
                if (o_rd_data !== exp_data || o_rd_last !== exp_last) begin
                    errors++;
                    $display("FAIL %s word %0d: got data=%h last=%b want data=%h last=%b",
                             name, got, o_rd_data, o_rd_last, exp_data, exp_last);
                end
                got++;
            end
            stalled   = (o_rd_valid === 1'b1) && !i_rd_ready;
            held_data = o_rd_data;
            held_last = o_rd_last;
            @(negedge clk);
            cyc++;
        end
        i_sample_vld = 1'b0;
        i_rd_ready   = 1'b0;

        checks++;
        if (got != DEPTH) begin
            errors++;
            $display("FAIL %s word_count: got %0d words want %0d (cycle budget)", name, got, DEPTH);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt);
        end
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_end: got %b want 0", name, o_busy);
        end
        checks++;
        if (o_trig_addr !== exp_ta) begin
            errors++;
            $display("FAIL %s trig_addr: got %0d want %0d", name, o_trig_addr, exp_ta);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; i_arm = 1'b0; i_abort = 1'b0; i_sample_vld = 1'b0;
        i_sample = '0; i_trig_level = 8'h80; i_rd_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({o_busy, o_trig_addr, o_rd_data, o_rd_valid, o_rd_last, o_done} !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b ta=%0d d=%h v=%b l=%b done=%b want all 0",
                     o_busy, o_trig_addr, o_rd_data, o_rd_valid, o_rd_last, o_done);
        end
    endtask

    task automatic test_ramp();
        gen_ramp();
        run_capture("ramp", 1, 100, 8'h80);
    endtask

    task automatic test_pretrig_ignore();
        gen_double_cross();
        run_capture("pretrig_ignore", 1, 100, 8'h80);
    endtask

    task automatic test_backpressure();
        gen_ramp();
        run_capture("backpressure", 1, 33, 8'h80);
    endtask

    task automatic test_sparse_valid();
        gen_ramp();
        run_capture("sparse_valid", 3, 100, 8'h80);
    endtask

    task automatic test_random();
        logic [7:0] level;
        int         t;
        for (int n = 0; n < 3; n++) begin
            for (int tries = 0; tries < 20; tries++) begin
                gen_random();
                level = 8'($urandom_range(8'h20, 8'hE0));
                t = find_trigger(level);
                if (t >= 0 && t + POST_LEN <= stim.size()) break;
            end
            run_capture("random", 1 + n, 50 + 25 * n, level);
        end
    endtask

    task automatic test_abort();
        bit saw;
        gen_ramp();
        arm(8'h80);
        stream(300, 1'b0, saw);     // trigger at sample 128, so now in POST
        checks++;
        if (o_busy !== 1'b1 || saw) begin
            errors++;
            $display("FAIL abort_pre_busy: got busy=%b readout=%b want 1/0", o_busy, saw);
        end
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_post: got busy=%b want 0", o_busy);
        end
        i_abort = 1'b1; i_arm = 1'b1;
        @(negedge clk);
        i_abort = 1'b0; i_arm = 1'b0;
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_wins_arm: got busy=%b want 0", o_busy);
        end
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_arm_later: got busy=%b want 0", o_busy);
        end
        run_capture("ramp_after_abort", 1, 100, 8'h80);

        // Abort while a word is waiting at the readout port.
        gen_ramp();
        arm(8'h80);
        stream(3000, 1'b1, saw);
        checks++;
        if (!saw) begin
            errors++;
            $display("FAIL abort_read_reach: got no readout within budget want valid");
        end
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        checks++;
        if (o_rd_valid !== 1'b0 || o_rd_last !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_read: got v=%b l=%b busy=%b want 0/0/0", o_rd_valid, o_rd_last, o_busy);
        end
        @(negedge clk);
        checks++;
        if (o_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_read_done: got %b want 0", o_done);
        end
    endtask

    task automatic test_no_trigger();
        bit saw;
        gen_const(8'h90);
        arm(8'h80);
        stream(1400, 1'b1, saw);
        checks++;
        if (saw || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL no_trigger: got readout=%b busy=%b want 0/1", saw, o_busy);
        end
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL no_trigger_abort: got busy=%b want 0", o_busy);
        end
    endtask

    task automatic test_reset_in_read();
        bit saw;
        gen_ramp();
        arm(8'h80);
        stream(3000, 1'b1, saw);
        checks++;
        if (!saw) begin
            errors++;
            $display("FAIL reset_read_reach: got no readout within budget want valid");
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_busy, o_trig_addr, o_rd_data, o_rd_valid, o_rd_last, o_done} !== '0) begin
            errors++;
            $display("FAIL reset_in_read: got busy=%b ta=%0d d=%h v=%b l=%b done=%b want all 0",
                     o_busy, o_trig_addr, o_rd_data, o_rd_valid, o_rd_last, o_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got busy=%b v=%b want 0/0", o_busy, o_rd_valid);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_pretrig_ignore();
        test_backpressure();
        test_sparse_valid();
        test_random();
        test_abort();
        test_no_trigger();
        test_reset_in_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_wave_capture_ram
